// File: rtl/mult_unit.sv
// Sequential shift-and-add multiplier, signed or unsigned, WIDTH iterations per product.
// Define MULT_UNIT_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module mult_unit #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   lhs,
  input  logic [WIDTH-1:0]   rhs,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               endSignal,
  output logic [CW-1:0]      counter
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic                 sign_reg;
  logic                 last_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 end_reg;
  logic [WIDTH-1:0]     lhs_abs, rhs_abs;
  logic                 exit_calc;
  logic                 do_iter;

  // Negation in WIDTH bits maps the most negative value onto 2^(WIDTH-1), which is its true magnitude.
  assign lhs_abs = (is_signed && lhs[WIDTH-1]) ? -lhs : lhs;
  assign rhs_abs = (is_signed && rhs[WIDTH-1]) ? -rhs : rhs;

`ifdef MULT_UNIT_EARLY_EXIT_EN
  assign exit_calc = last_reg || (mplier_reg == '0);
`else
  assign exit_calc = last_reg;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (exit_calc) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign do_iter = (state_reg == CALC) && !exit_calc;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      sign_reg   <= 1'b0;
      last_reg   <= 1'b0;
      count_reg  <= '0;
      result_reg <= '0;
      end_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      end_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, lhs_abs};
            mplier_reg <= rhs_abs;
            sign_reg   <= is_signed & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
            acc_reg    <= '0;
            count_reg  <= '0;
            last_reg   <= 1'b0;
          end
        end
        CALC: begin
          if (do_iter) begin
            if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            // counter stops on the last index so it keeps naming the final iteration
            if (count_reg == CW'(WIDTH-1)) last_reg <= 1'b1;
            else                           count_reg <= count_reg + 1'b1;
          end
        end
        SIGN: begin
          result_reg <= sign_reg ? -acc_reg : acc_reg;
          end_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_reg;
  assign busy      = (state_reg != IDLE);
  assign endSignal = end_reg;
  assign counter   = count_reg;

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal range 4..64.
REQ-002 The block SHALL have derived localparam CW = $clog2(WIDTH), giving the iteration counter width.
REQ-003 Port Clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-low.
REQ-005 Port start  input  1  request; sampled only in IDLE.
REQ-006 Port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
REQ-007 Port lhs  input  WIDTH  multiplicand; latched with start.
REQ-008 Port rhs  input  WIDTH  multiplier; latched with start.
REQ-009 Port result  output  2*WIDTH  product; holds its value until the next done.
REQ-010 Port busy  output  1  high while not in IDLE.
REQ-011 Port endSignal  output  1  one-cycle done pulse, asserted in the cycle the result becomes valid.
REQ-012 Port counter  output  CW  index of the current or last CALC iteration.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and SIGN.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch is_signed, load |lhs| and |rhs| (absolute values when signed, raw values otherwise), record sign = lhs[MSB]^rhs[MSB] (signed only), clear the accumulator and counter, and go to CALC.
REQ-015 In CALC, each edge SHALL add the shifted multiplicand to the accumulator when multiplier bit 0 = 1, then shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
REQ-016 After exactly WIDTH CALC iterations (counter = WIDTH-1 on the last one), the FSM SHALL go to SIGN.
REQ-017 In SIGN, the block SHALL write result = sign ? -acc : acc (2*WIDTH-bit two's complement), pulse endSignal for one cycle, and return to IDLE.
REQ-018 Latency without early exit SHALL be WIDTH+2 edges from E0 to the edge that raises endSignal.
REQ-019 The accumulator SHALL be 2*WIDTH bits with no overflow; |-2^(WIDTH-1)| SHALL be handled as an unsigned 2^(WIDTH-1).
REQ-020 A start asserted while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-021 A start asserted in the endSignal cycle (state IDLE) SHALL be accepted; endSignal SHALL drop on the next edge.
REQ-022 Latched operands SHALL NOT be affected by lhs, rhs or is_signed changes after E0.
REQ-023 counter SHALL hold its last value in IDLE until the next accepted start.

Reset
REQ-024 With reset=0 at a rising edge, the FSM SHALL go to IDLE and outputs SHALL be result=0, endSignal=0, busy=0, counter=0, regardless of state.
REQ-025 Reset mid-operation SHALL abort the operation with no endSignal pulse; result SHALL become 0.
REQ-026 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro MULT_UNIT_EARLY_EXIT_EN: when defined, in CALC with a multiplier register of 0, the block SHALL go directly to SIGN without iterating; counter freezes.
REQ-028 Without MULT_UNIT_EARLY_EXIT_EN, latency SHALL always be fixed per REQ-018.
REQ-029 The result value SHALL be identical with and without MULT_UNIT_EARLY_EXIT_EN.

Verification (WIDTH=32)
REQ-030 Unsigned 7*6 -> result=64'd42; endSignal exactly 34 edges after E0 (macro off).
REQ-031 Signed -3*5 -> result=64'hFFFFFFFFFFFFFFF1; unsigned 0xFFFFFFFF*0xFFFFFFFF -> 64'hFFFFFFFE00000001.
REQ-032 Signed 0x80000000*0x80000000 -> 64'h4000000000000000; signed 0x80000000*1 -> 64'hFFFFFFFF80000000.
REQ-033 start pulsed at iteration 10 with new operands -> ignored; original product delivered; back-to-back start in the endSignal cycle -> second product correct.
REQ-034 reset=0 at iteration 15 -> next cycle busy=0, result=0, no endSignal; a subsequent 2*3 -> 6.
REQ-035 Macro on: rhs=0 -> endSignal 2 edges after E0, result=0; rhs=1, lhs=9 -> endSignal 3 edges after E0, result=9.
